// File: rtl/cgra_thread_dispatch.sv
// Per-warp thread sequencer: issues one RF row read per granted cycle, tracks it through the fixed-latency fabric and raises the matching writeback.
// Optional perf counters are enabled by defining CGRA_DISPATCH_PERF_EN.
module cgra_thread_dispatch #(
  parameter int NUM_PORTS      = 4,
  parameter int NUM_THREADS    = 32,
  parameter int MAX_PIPE_STAGE = 16,
  parameter int LAT_W          = $clog2(4*MAX_PIPE_STAGE),
  parameter int TID_W          = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   start,
  input  logic [NUM_THREADS-1:0] thread_mask,
  input  logic [LAT_W-1:0]       pipe_latency,
  output logic                   rf_rd_en,
  output logic [TID_W-1:0]       rf_rd_tid,
  input  logic                   rf_rd_gnt,
  output logic                   rf_wr_en,
  output logic [TID_W-1:0]       rf_wr_tid,
  output logic                   busy,
  output logic                   done
`ifdef CGRA_DISPATCH_PERF_EN
  ,
  output logic [31:0]            perf_busy_cycles,
  output logic [31:0]            perf_stall_cycles
`endif
);
  localparam int LINE_D = 4*MAX_PIPE_STAGE-1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NUM_THREADS-1:0] rem_mask;
  logic [LAT_W-1:0]       lat_q;
  logic [TID_W:0]         inflight;
  logic                   line_vld [LINE_D];
  logic [TID_W-1:0]       line_tid [LINE_D];

  logic             accept, issue, last_issue, tap_vld;
  logic [TID_W-1:0] push_tid, tap_tid;
  logic [LAT_W-1:0] tap_sel;

  assign accept     = (state == IDLE) && start;
  assign rf_rd_en   = (state == ISSUE);
  assign issue      = rf_rd_en && rf_rd_gnt;
  assign last_issue = (rem_mask & (rem_mask - NUM_THREADS'(1))) == '0;
  assign busy       = (state == ISSUE) || (state == DRAIN);
  assign done       = (state == DONE);
  assign push_tid   = issue ? rf_rd_tid : '0;

  always_comb begin
    rf_rd_tid = '0;
    if (state == ISSUE) begin
      for (int i = NUM_THREADS-1; i >= 0; i--) begin
        if (rem_mask[i]) rf_rd_tid = TID_W'(i);
      end
    end
  end

  // Tap 0 is the push itself so a latency of 1 lands in the writeback register directly.
  always_comb begin
    tap_sel = lat_q - LAT_W'(1);
    tap_vld = issue;
    tap_tid = push_tid;
    if (tap_sel != '0) begin
      tap_vld = line_vld[tap_sel - LAT_W'(1)];
      tap_tid = line_tid[tap_sel - LAT_W'(1)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (|thread_mask) ? ISSUE : DONE;
      ISSUE:   if (issue && last_issue) state_nxt = DRAIN;
      DRAIN:   if (inflight == (TID_W+1)'(1) && rf_wr_en) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_mask  <= '0;
      lat_q     <= '0;
      inflight  <= '0;
      rf_wr_en  <= 1'b0;
      rf_wr_tid <= '0;
      for (int i = 0; i < LINE_D; i++) begin
        line_vld[i] <= 1'b0;
        line_tid[i] <= '0;
      end
    end else if (clr) begin
      rem_mask  <= '0;
      inflight  <= '0;
      rf_wr_en  <= 1'b0;
      rf_wr_tid <= '0;
      for (int i = 0; i < LINE_D; i++) begin
        line_vld[i] <= 1'b0;
        line_tid[i] <= '0;
      end
    end else begin
      if (accept) begin
        rem_mask <= thread_mask;
        lat_q    <= (pipe_latency == '0) ? LAT_W'(1) : pipe_latency;
      end else if (issue) begin
        rem_mask <= rem_mask & (rem_mask - NUM_THREADS'(1));
      end
      // Dead entries of the previous warp sit beyond its tap; flush them so a longer latency cannot re-tap them.
      for (int i = LINE_D-1; i > 0; i--) begin
        line_vld[i] <= accept ? 1'b0 : line_vld[i-1];
        line_tid[i] <= accept ? '0   : line_tid[i-1];
      end
      line_vld[0] <= issue;
      line_tid[0] <= push_tid;
      rf_wr_en    <= tap_vld;
      rf_wr_tid   <= tap_tid;
      if (issue && !rf_wr_en)      inflight <= inflight + (TID_W+1)'(1);
      else if (!issue && rf_wr_en) inflight <= inflight - (TID_W+1)'(1);
    end
  end

`ifdef CGRA_DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == ISSUE && !rf_rd_gnt && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  a_ports:    assert property (@(posedge clk) NUM_PORTS > 0);
  a_inflight: assert property (@(posedge clk) disable iff (!rst_n) inflight <= (TID_W+1)'(NUM_THREADS));

endmodule

// File: tb/tb_cgra_thread_dispatch.sv
// Directed warp scenarios with randomized grants/masks, checked cycle by cycle against a schedule model.
module tb_cgra_thread_dispatch;
  localparam int NT = 32;
  localparam int LW = 6;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n, clr, start, rf_rd_gnt;
  logic [NT-1:0] thread_mask;
  logic [LW-1:0] pipe_latency;
  logic          rf_rd_en, rf_wr_en, busy, done;
  logic [TW-1:0] rf_rd_tid, rf_wr_tid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cgra_thread_dispatch dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
    .thread_mask(thread_mask), .pipe_latency(pipe_latency),
    .rf_rd_en(rf_rd_en), .rf_rd_tid(rf_rd_tid), .rf_rd_gnt(rf_rd_gnt),
    .rf_wr_en(rf_wr_en), .rf_wr_tid(rf_wr_tid), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int low_bit(input logic [31:0] m);
    for (int i = 0; i < 32; i++) if (m[i]) return i;
    return -1;
  endfunction

  // gmode: 0 grant always, 1 random grant, 2 grant low in cycles 2..3. clr_at < 0 means no abort.
  task automatic run_warp(input logic [31:0] mask, input int lat, input int gmode,
                          input int clr_at, output int done_c);
    logic [31:0] rem;
    int          wt[$];
    int          wid[$];
    int          lq, maxw, exp_rd_tid, exp_wr_tid;
    bit          aborted, finished, g, exp_rd, exp_wr, exp_done, exp_busy;
    lq = (lat == 0) ? 1 : lat;
    rem = mask; maxw = 0; aborted = 0; finished = 0; done_c = -1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      clr   = (c == clr_at);
      if (c == 0) begin
        thread_mask  = mask;
        pipe_latency = LW'(lat);
      end else begin
        thread_mask  = $urandom;
        pipe_latency = LW'($urandom);
      end
      case (gmode)
        0:       g = 1'b1;
        1:       g = ($urandom_range(0, 3) != 0);
        default: g = !(c == 2 || c == 3);
      endcase
      rf_rd_gnt = g;
      @(negedge clk);
      exp_rd     = !aborted && c >= 1 && rem != 0;
      exp_rd_tid = exp_rd ? low_bit(rem) : 0;
      exp_wr = 0; exp_wr_tid = 0;
      foreach (wt[i]) if (wt[i] == c) begin exp_wr = 1; exp_wr_tid = wid[i]; end
      exp_done = !aborted && rem == 0 && c == maxw + 1;
      exp_busy = !aborted && mask != 0 && c >= 1 && (rem != 0 || c <= maxw);
      chk("rd_en", 32'(rf_rd_en), 32'(exp_rd));
      if (exp_rd) chk("rd_tid", 32'(rf_rd_tid), 32'(exp_rd_tid));
      chk("wr_en", 32'(rf_wr_en), 32'(exp_wr));
      if (exp_wr) chk("wr_tid", 32'(rf_wr_tid), 32'(exp_wr_tid));
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (done === 1'b1 && done_c < 0) done_c = c;
      if (exp_rd && g) begin
        wt.push_back(c + lq);
        wid.push_back(exp_rd_tid);
        if (c + lq > maxw) maxw = c + lq;
        rem[exp_rd_tid] = 1'b0;
      end
      if (c == clr_at) begin
        aborted = 1; rem = 0; wt.delete(); wid.delete();
      end
      if (aborted ? (c >= clr_at + 30) : (rem == 0 && c == maxw + 1)) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    clr   = 1'b0;
    if (!finished) begin
      checks++;
      failures++;
      $error("FAIL warp_timeout observed=running expected=finished");
    end
  endtask

  initial begin
    int          d;
    logic [31:0] m;
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; rf_rd_gnt = 1'b0;
    thread_mask = '0; pipe_latency = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en",  32'(rf_rd_en),  32'd0);
    chk("rst_rd_tid", 32'(rf_rd_tid), 32'd0);
    chk("rst_wr_en",  32'(rf_wr_en),  32'd0);
    chk("rst_wr_tid", 32'(rf_wr_tid), 32'd0);
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_done",   32'(done),      32'd0);
    rst_n = 1'b1;

    run_warp(32'hFFFF_FFFF, 5, 0, -1, d);
    chk("full_done_cycle", 32'(d), 32'd38);
    run_warp(32'h8000_0005, 3, 0, -1, d);
    chk("sparse_done_cycle", 32'(d), 32'd7);
    run_warp(32'h0000_000F, 4, 2, -1, d);
    chk("gnt_gap_done_cycle", 32'(d), 32'd11);
    run_warp(32'h0, 7, 1, -1, d);
    chk("empty_done_cycle", 32'(d), 32'd1);
    run_warp(32'h0000_000F, 20, 0, 10, d);
    chk("clr_no_done", 32'(d), 32'hFFFF_FFFF);
    m = $urandom;
    run_warp(m, int'($urandom_range(1, 9)), 0, -1, d);

    m = 32'h1 << $urandom_range(0, 31);
    run_warp(m, 0, 0, -1, d);
    chk("lat0_done_cycle", 32'(d), 32'd3);
    m = 32'h1 << $urandom_range(0, 31);
    run_warp(m, 63, 0, -1, d);
    chk("lat63_done_cycle", 32'(d), 32'd65);

    for (int k = 0; k < 6; k++) begin
      m = $urandom & $urandom;
      run_warp(m, int'($urandom_range(0, 63)), 1, -1, d);
    end
    m = 32'h00F0_0F00;
    run_warp(m, 12, 1, 6, d);
    chk("clr_issue_no_done", 32'(d), 32'hFFFF_FFFF);
    run_warp(32'h0000_0300, 2, 0, -1, d);
    chk("after_clr_done_cycle", 32'(d), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cgra_thread_dispatch.md
# cgra_thread_dispatch

Per-warp thread sequencer that drives the operand register file feeding the CGRA latency I/O stage. It issues one active thread's register-file read per granted cycle and tracks each issued thread through the fixed-latency fabric: RF read, input delay, CGRA, output delay. Each result arrives on `rf_wdata` aligned with a write enable and thread ID. It sits directly upstream, and on the write side downstream, of the latency I/O block. It owns the RF row addressing that block lacks.

## Interface
- `NUM_PORTS`, default 4: operand ports per thread. Only used for documentation and assertions; data does not pass through this block.
- `NUM_THREADS`, default 32: threads per warp.
- `MAX_PIPE_STAGE`, default 16: per-pipe maximum stage count. Sets `LAT_W = $clog2(4*MAX_PIPE_STAGE)`.
- `TID_W`, default `$clog2(NUM_THREADS)`: thread ID width.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort and flush.
- `start`  in  1  launch a warp. Only accepted in IDLE.
- `thread_mask`  in  NUM_THREADS  active threads. Sampled on the accepted `start`.
- `pipe_latency`  in  LAT_W  cycles from RF read issue to `rf_wdata` valid. Sampled on the accepted `start`.
- `rf_rd_en`  out  1  read request for `rf_rd_tid`.
- `rf_rd_tid`  out  TID_W  thread row to read.
- `rf_rd_gnt`  in  1  read accepted this cycle.
- `rf_wr_en`  out  1  write `rf_wdata` to row `rf_wr_tid`.
- `rf_wr_tid`  out  TID_W  writeback row.
- `busy`  out  1  high in ISSUE and DRAIN.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE transitions on `start`:
  - Latch `rem_mask <= thread_mask`.
  - Latch `lat_q <= max(pipe_latency, 1)`.
  - Go to ISSUE if the mask is nonzero, otherwise go to DONE.
- ISSUE: `rf_rd_en = 1` and `rf_rd_tid` = lowest set bit of `rem_mask`. Both are combinational from state.
  - An issue happens when `rf_rd_en && rf_rd_gnt`. That cycle clears the bit and pushes `{valid=1, tid}` into the tracking line.
  - When `rf_rd_gnt = 0`, nothing changes.
  - The issue that clears the last bit moves the FSM to DRAIN.
- Tracking line: a shift register of depth `4*MAX_PIPE_STAGE-1`, entries `{valid, tid}`, advancing every cycle.
  - It is tapped at position `lat_q`.
  - `rf_wr_en` and `rf_wr_tid` are registered from that tap.
- In-flight counter, width `TID_W+1`:
  - +1 on issue, -1 on writeback.
  - Unchanged when both happen in the same cycle.
- DRAIN goes to DONE in the cycle the final writeback is presented, i.e. when the counter is 1 and `rf_wr_en` is high.
- DONE: `done = 1` for one cycle, then IDLE.
- `start` outside IDLE is ignored. `thread_mask` and `pipe_latency` changes outside IDLE have no effect.
- `clr` (sync), any state:
  - Next state IDLE.
  - `rem_mask`, the tracking line, and the counter are zeroed.
  - `rf_wr_en` is 0 the next cycle.
  - `done` is not pulsed.
  - `clr` has priority over `start`.
- Asynchronous `rst_n` mid-warp has the same effect as `clr`, applied immediately.

## Timing
- Reset values:
  - `rf_rd_en`, `rf_wr_en`, `busy`, `done` = 0.
  - `rf_rd_tid`, `rf_wr_tid` = 0.
  - State IDLE; all internal registers 0.
- `start` accepted at cycle 0 → ISSUE at cycle 1, with the first `rf_rd_en` at cycle 1.
- An issue at cycle t → `rf_wr_en` with the same tid at cycle t+`lat_q`.
- Throughput: one issue per granted cycle, with no bubbles for inactive threads.
- Last writeback at cycle w → `done` at cycle w+1 → IDLE at w+2, where `start` may be accepted.
- Empty mask: `start` at cycle 0 → `done` at cycle 1, with no RF traffic.
- `pipe_latency = 0` is treated as 1.

## Configuration
- `CGRA_DISPATCH_PERF_EN` defined:
  - Adds outputs `perf_busy_cycles [31:0]` and `perf_stall_cycles [31:0]`.
  - `perf_busy_cycles` counts cycles with `busy = 1`.
  - `perf_stall_cycles` counts ISSUE cycles with `rf_rd_gnt = 0`.
  - Both saturate at all-ones, reset to 0 on `rst_n`, and are not cleared by `clr`.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Full mask, `pipe_latency=5`, `rf_rd_gnt=1`, `start`@0:
  - Reads of tid 0..31 at cycles 1..32.
  - Writes of tid 0..31 at cycles 6..37.
  - `done`@38.
- Mask `0x8000_0005`, `pipe_latency=3`: reads of tid 0, 2, 31 at cycles 1–3; writes at cycles 4–6 in the same order; `done`@7.
- Mask `0x0000_000F`, `rf_rd_gnt` low at cycles 2–3:
  - Tid 1 is held on `rf_rd_tid` until cycle 4.
  - Writeback spacing shows the 2-cycle gap.
- `thread_mask=0`: `done` at cycle 1; `rf_rd_en` and `rf_wr_en` never asserted.
- `clr` asserted during DRAIN with 4 threads in flight: zero further `rf_wr_en`, no `done`, IDLE next cycle. A following `start` runs cleanly.
- `pipe_latency=0` and `pipe_latency=63` (MAX_PIPE_STAGE=16), single thread: writeback at issue+1 and issue+63 respectively.
